// File: rtl/tube_host_master.sv
// Host-side initiator for the Tube ULA host port: turns simple commands into PHI2 bus cycles,
// polling the channel status register before data transfers, and synchronises the Tube IRQ.
module tube_host_master #(
  parameter int PHI2_HALF = 4,
  parameter int POLL_MAX  = 255
) (
  input  logic       clk,
  input  logic       h_rst_b,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_chan,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       h_phi2,
  output logic       h_cs_b,
  output logic       h_rdnw,
  output logic [2:0] h_addr,
  output logic [7:0] h_data_o,
  output logic       h_data_oe,
  input  logic [7:0] h_data_i,
  input  logic       h_irq_b,
  output logic       host_irq
);

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP, S_RESP} state_t;

  localparam int HW = (PHI2_HALF <= 2) ? 1 : $clog2(PHI2_HALF);
  localparam int PW = (POLL_MAX <= 1) ? 1 : $clog2(POLL_MAX + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(PHI2_HALF - 1);
  localparam logic [PW-1:0] POLL_LIM  = PW'(POLL_MAX);

  state_t        state, state_n;
  logic [HW-1:0] phase_cnt;
  logic [PW-1:0] poll_cnt, poll_nxt;
  logic [1:0]    op_q, chan_q;
  logic [7:0]    data_q, rd_q;
  logic          is_poll, accept, last_half, wr_cycle, cond_met, poll_limit, in_bus;
  logic [2:0]    bus_addr;
  logic          irq_s1;

  assign last_half  = (phase_cnt == HALF_LAST);
  // Only the data transfer of op00 and the control write drive the bus; everything else reads.
  assign wr_cycle   = !is_poll && !op_q[0];
  assign cond_met   = op_q[0] ? rd_q[7] : rd_q[6];
  assign poll_nxt   = poll_cnt + PW'(1);
  assign poll_limit = (POLL_MAX != 0) && (poll_nxt == POLL_LIM);
  assign in_bus     = (state == S_LOW) || (state == S_HIGH) || (state == S_HOLD);

  always_comb begin
    bus_addr = {chan_q, 1'b1};
    if (is_poll || op_q == 2'b11) bus_addr = {chan_q, 1'b0};
    else if (op_q == 2'b10)       bus_addr = 3'b000;
  end

  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    h_phi2    = 1'b0;
    h_cs_b    = 1'b1;
    h_rdnw    = 1'b1;
    h_addr    = 3'b000;
    h_data_o  = 8'h00;
    h_data_oe = 1'b0;
    if (in_bus) begin
      h_cs_b = 1'b0;
      h_rdnw = !wr_cycle;
      h_addr = bus_addr;
    end
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = S_LOW;
        end
      end
      S_LOW:  if (last_half) state_n = S_HIGH;
      S_HIGH: begin
        h_phi2    = 1'b1;
        h_data_o  = wr_cycle ? data_q : 8'h00;
        h_data_oe = wr_cycle;
        if (last_half) state_n = S_HOLD;
      end
      // Data and enable stay put one clk past the PHI2 fall, where the Tube latches writes.
      S_HOLD: begin
        h_data_o  = wr_cycle ? data_q : 8'h00;
        h_data_oe = wr_cycle;
        state_n   = S_GAP;
      end
      S_GAP:  state_n = (is_poll && (cond_met || !poll_limit)) ? S_LOW : S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      phase_cnt <= '0;
      poll_cnt  <= '0;
      op_q      <= 2'b00;
      chan_q    <= 2'b00;
      data_q    <= 8'h00;
      rd_q      <= 8'h00;
      is_poll   <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      phase_cnt <= ((state == S_LOW || state == S_HIGH) && !last_half) ? phase_cnt + HW'(1) : '0;
      if (accept) begin
        op_q     <= cmd_op;
        chan_q   <= cmd_chan;
        data_q   <= cmd_data;
        is_poll  <= !cmd_op[1];
        poll_cnt <= '0;
      end
      if (state == S_HIGH && last_half && !wr_cycle) rd_q <= h_data_i;
      // Outcome of the cycle just finished is settled in the gap clk.
      if (state == S_GAP) begin
        if (!is_poll) begin
          rsp_err  <= 1'b0;
          rsp_data <= op_q[0] ? rd_q : data_q;
        end else if (cond_met) begin
          is_poll <= 1'b0;
        end else begin
          poll_cnt <= poll_nxt;
          if (poll_limit) begin
            rsp_err  <= 1'b1;
            rsp_data <= rd_q;
          end
        end
      end
      if (state == S_RESP) poll_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      irq_s1   <= 1'b0;
      host_irq <= 1'b0;
    end else begin
      irq_s1   <= !h_irq_b;
      host_irq <= irq_s1;
    end
  end

endmodule

// File: tb/tb_tube_host_master.sv
// Scoreboard bench for tube_host_master: a Tube slave model feeds read data from a queue, and
// independent monitors compare every bus cycle and response against expectations.
module tb_tube_host_master;

  localparam int PHI2_HALF = 4;
  localparam int POLL_MAX  = 4;

  logic       clk, h_rst_b, cmd_valid, cmd_ready, rsp_valid, rsp_err;
  logic [1:0] cmd_op, cmd_chan;
  logic [7:0] cmd_data, rsp_data, h_data_o, h_data_i;
  logic       h_phi2, h_cs_b, h_rdnw, h_data_oe, h_irq_b, host_irq;
  logic [2:0] h_addr;

  typedef struct {logic [2:0] addr; logic rdnw; logic [7:0] wdata;} bus_t;
  typedef struct {logic [7:0] data; logic err;} rsp_t;

  bus_t       exp_bus[$];
  rsp_t       exp_rsp[$];
  logic [7:0] rd_vals[$];
  int         errors = 0, checks = 0, bus_cycles = 0, rsp_seen = 0;
  logic [6:0] model_ctrl = 7'h00;

  tube_host_master #(.PHI2_HALF(PHI2_HALF), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .h_rst_b(h_rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_chan(cmd_chan), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .h_phi2(h_phi2), .h_cs_b(h_cs_b),
    .h_rdnw(h_rdnw), .h_addr(h_addr), .h_data_o(h_data_o), .h_data_oe(h_data_oe),
    .h_data_i(h_data_i), .h_irq_b(h_irq_b), .host_irq(host_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic failNow(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bus_t mkBus(input logic [2:0] addr, input logic rdnw, input logic [7:0] wdata);
    bus_t b;
    b.addr  = addr;
    b.rdnw  = rdnw;
    b.wdata = wdata;
    return b;
  endfunction

  // Reference model: the bus cycles, slave replies and response a command should produce.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] chan, input logic [7:0] data,
                               input int nfail, input logic [7:0] rdata);
    bus_t       b[$];
    logic [7:0] r[$];
    rsp_t       rs;
    logic [7:0] st;
    logic [6:0] ctrl_n;
    int         polls, bitn;
    bit         accepted;
    ctrl_n = model_ctrl;
    st     = 8'h00;
    case (op)
      2'b10: begin
        b.push_back(mkBus(3'b000, 1'b0, data));
        ctrl_n = data[7] ? (model_ctrl | data[6:0]) : (model_ctrl & ~data[6:0]);
        rs.data = data;
        rs.err  = 1'b0;
      end
      2'b11: begin
        st = {1'($urandom_range(0, 1)), model_ctrl};
        b.push_back(mkBus({chan, 1'b0}, 1'b1, 8'h00));
        r.push_back(st);
        rs.data = st;
        rs.err  = 1'b0;
      end
      default: begin
        bitn  = (op == 2'b00) ? 6 : 7;
        polls = (nfail >= POLL_MAX) ? POLL_MAX : nfail;
        for (int i = 0; i < polls; i++) begin
          st = 8'($urandom);
          st[bitn] = 1'b0;
          b.push_back(mkBus({chan, 1'b0}, 1'b1, 8'h00));
          r.push_back(st);
        end
        if (nfail >= POLL_MAX) begin
          rs.data = st;
          rs.err  = 1'b1;
        end else begin
          st = 8'($urandom);
          st[bitn] = 1'b1;
          b.push_back(mkBus({chan, 1'b0}, 1'b1, 8'h00));
          r.push_back(st);
          if (op == 2'b00) begin
            b.push_back(mkBus({chan, 1'b1}, 1'b0, data));
            rs.data = data;
          end else begin
            b.push_back(mkBus({chan, 1'b1}, 1'b1, 8'h00));
            r.push_back(rdata);
            rs.data = rdata;
          end
          rs.err = 1'b0;
        end
      end
    endcase
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_chan  = chan;
    cmd_data  = data;
    accepted  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_chan  = 2'($urandom_range(0, 3));
      cmd_data  = 8'($urandom);
      foreach (b[i]) exp_bus.push_back(b[i]);
      foreach (r[i]) rd_vals.push_back(r[i]);
      exp_rsp.push_back(rs);
      model_ctrl = ctrl_n;
    end else begin
      cmd_valid = 1'b0;
      failNow("ready_timeout", 0, 1);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_bus.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) failNow("drain_timeout", exp_rsp.size(), 0);
  endtask

  // Tube slave model and bus cycle monitor.
  logic       in_cyc = 0, cyc_rdnw, cyc_stable, hold_oe;
  logic [2:0] cyc_addr;
  logic [7:0] hold_data, high_data;
  int         low_n, high_n, hold_n;
  bus_t       mon_e;
  always @(negedge clk) begin
    if (!h_rst_b) begin
      in_cyc = 0;
    end else if (!h_cs_b) begin
      if (!in_cyc) begin
        in_cyc = 1; low_n = 0; high_n = 0; hold_n = 0;
        cyc_addr = h_addr; cyc_rdnw = h_rdnw; cyc_stable = 1;
        hold_oe = 0; hold_data = 8'h00; high_data = 8'h00;
        if (h_rdnw) h_data_i = (rd_vals.size() > 0) ? rd_vals.pop_front() : 8'h00;
      end
      if (h_addr !== cyc_addr || h_rdnw !== cyc_rdnw) cyc_stable = 0;
      if (h_phi2) begin
        high_n++;
        high_data = h_data_o;
        if (h_data_oe !== !cyc_rdnw) cyc_stable = 0;
      end else if (high_n == 0) begin
        low_n++;
        if (h_data_oe !== 1'b0) cyc_stable = 0;
      end else begin
        hold_n++;
        hold_data = h_data_o;
        hold_oe   = h_data_oe;
      end
    end else if (in_cyc) begin
      in_cyc = 0;
      bus_cycles++;
      if (exp_bus.size() == 0) begin
        failNow("bus_unexpected", {28'h0, cyc_rdnw, cyc_addr}, 0);
      end else begin
        mon_e = exp_bus.pop_front();
        checkOutput("bus_addr", cyc_addr, mon_e.addr);
        checkOutput("bus_rdnw", cyc_rdnw, mon_e.rdnw);
        checkOutput("bus_shape", {cyc_stable, 4'(hold_n), 8'(high_n), 8'(low_n)},
                    {1'b1, 4'd1, 8'(PHI2_HALF), 8'(PHI2_HALF)});
        if (!mon_e.rdnw) begin
          checkOutput("bus_wdata_high", high_data, mon_e.wdata);
          checkOutput("bus_wdata_hold", {hold_oe, hold_data}, {1'b1, mon_e.wdata});
        end
      end
    end
  end

  rsp_t mon_r;
  always @(negedge clk) begin
    if (h_rst_b && rsp_valid) begin
      rsp_seen++;
      if (exp_rsp.size() == 0) begin
        failNow("rsp_unexpected", {rsp_err, rsp_data}, 0);
      end else begin
        mon_r = exp_rsp.pop_front();
        checkOutput("rsp_data", rsp_data, mon_r.data);
        checkOutput("rsp_err", rsp_err, mon_r.err);
      end
    end
  end

  initial begin
    int  cyc0, rsp0;
    bit  found;
    h_rst_b = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_chan = 2'b00; cmd_data = 8'h00;
    h_data_i = 8'h00; h_irq_b = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_bus", {h_phi2, h_cs_b, h_rdnw, h_addr, h_data_oe}, {1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
    checkOutput("rst_data_o", h_data_o, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    checkOutput("rst_host_irq", host_irq, 0);
    #20;
    @(negedge clk);
    h_rst_b = 1'b1;

    applyStimulus(2'b10, 2'd0, 8'h3F, 0, 8'h00);
    applyStimulus(2'b11, 2'd0, 8'h00, 0, 8'h00);
    applyStimulus(2'b10, 2'd0, 8'h85, 0, 8'h00);
    applyStimulus(2'b11, 2'd0, 8'h00, 0, 8'h00);
    applyStimulus(2'b00, 2'd0, 8'hA5, 0, 8'h00);
    applyStimulus(2'b01, 2'd3, 8'h00, 3, 8'h5C);
    applyStimulus(2'b00, 2'd1, 8'h77, 4, 8'h00);
    applyStimulus(2'b01, 2'd2, 8'h00, 9, 8'h00);
    waitDrain();

    for (int i = 0; i < 30; i++)
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
                    int'($urandom_range(0, 5)), 8'($urandom));
    waitDrain();

    cyc0 = bus_cycles;
    @(negedge clk); h_irq_b = 1'b0;
    @(negedge clk); checkOutput("irq_after_1clk", host_irq, 0);
    @(negedge clk); checkOutput("irq_after_2clk", host_irq, 1);
    h_irq_b = 1'b1;
    @(negedge clk); checkOutput("irq_release_1clk", host_irq, 1);
    @(negedge clk); checkOutput("irq_release_2clk", host_irq, 0);
    checkOutput("irq_no_bus", bus_cycles - cyc0, 0);

    // Reset in the HIGH phase of a data write must drop the bus at once and lose the command.
    rsp0 = rsp_seen;
    applyStimulus(2'b00, 2'd2, 8'hC3, 0, 8'h00);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (h_phi2 && !h_rdnw) begin
        found = 1;
        break;
      end
    end
    checkOutput("abort_write_seen", found, 1);
    #2 h_rst_b = 1'b0;
    #1;
    checkOutput("abort_bus", {h_phi2, h_cs_b, h_rdnw, h_data_oe}, {1'b0, 1'b1, 1'b1, 1'b0});
    checkOutput("abort_ready", cmd_ready, 1);
    exp_bus.delete();
    exp_rsp.delete();
    rd_vals.delete();
    repeat (3) @(negedge clk);
    h_rst_b = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("abort_no_rsp", rsp_seen - rsp0, 0);
    checkOutput("abort_ready_after", cmd_ready, 1);

    applyStimulus(2'b00, 2'd2, 8'h3C, 1, 8'h00);
    applyStimulus(2'b01, 2'd1, 8'h00, 0, 8'hE7);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
